// File: rtl/rdcntrl_win.sv
// Read-controller match window: tracks LCT/L1A matches over a sliding block window and
// queues one readout descriptor per qualifying block. Optional L1A tagging: RDCNTRL_WIN_L1A_TAG_EN.
module rdcntrl_win #(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned FDEPTH = 8,
  parameter int unsigned BLKW   = 4,
  parameter int unsigned L1NW   = 6
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PBEND,
  input  logic                     MATCH,
  input  logic                     NO_MATCH,
  input  logic                     GTRG,
  input  logic [2:0]               WIN,
  input  logic [BLKW-1:0]          BLKIN,
  input  logic                     POP,
  output logic                     NOGTRG,
  output logic                     DAV,
  output logic                     FULL,
  output logic                     OVFL,
  output logic [$clog2(FDEPTH):0]  COUNT,
  output logic [BLKW-1:0]          BLKOUT,
  output logic                     SCND_BLK,
  output logic                     SCND_SHARED,
  output logic [L1NW-1:0]          L1ANUM
);

  localparam int unsigned AW   = $clog2(FDEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned LAST = NSTAGE + 1;
  localparam int unsigned DW   = BLKW + 2 + L1NW;

  typedef enum logic [1:0] {StIdle, StEval, StPush} state_e;

  // ---------------------------------------------------------------------------
  // Match / no-match block pipelines; stage 1 accumulates the current block.
  // ---------------------------------------------------------------------------
  logic [LAST:1] f_q, l_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      f_q <= '0;
      l_q <= '0;
    end else begin
      f_q[1] <= MATCH | (f_q[1] & ~PBEND);
      l_q[1] <= NO_MATCH | (l_q[1] & ~PBEND);
      if (PBEND) begin
        f_q[LAST:2] <= f_q[LAST-1:1];
        l_q[LAST:2] <= l_q[LAST-1:1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window evaluation over completed blocks 2..w+1
  // ---------------------------------------------------------------------------
  int unsigned w_eff;
  logic        yes, lno, f_w, f_w1;

  always_comb begin
    w_eff = 32'(WIN) + 32'd1;
    if (w_eff > NSTAGE) w_eff = NSTAGE;
    yes  = 1'b0;
    lno  = 1'b0;
    f_w  = 1'b0;
    f_w1 = 1'b0;
    for (int unsigned k = 1; k <= LAST; k++) begin
      if (k >= 2 && k <= w_eff + 1) begin
        yes = yes | f_q[k];
        lno = lno | l_q[k];
      end
      if (k == w_eff)     f_w  = f_q[k];
      if (k == w_eff + 1) f_w1 = f_q[k];
    end
  end

  assign NOGTRG = lno & ~yes;

  // ---------------------------------------------------------------------------
  // L1A counter and tag pipeline
  // ---------------------------------------------------------------------------
  logic [L1NW-1:0] tag_sel;

`ifdef RDCNTRL_WIN_L1A_TAG_EN
  logic [L1NW-1:0] cnt_q;
  logic [L1NW-1:0] t_q [LAST:1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      for (int unsigned k = 1; k <= LAST; k++) t_q[k] <= '0;
    end else begin
      if (GTRG) cnt_q <= cnt_q + L1NW'(1);
      // First match of a block: stage 1 is empty, or the block is closing this cycle.
      if (MATCH & (PBEND | ~f_q[1])) t_q[1] <= cnt_q;
      if (PBEND) begin
        for (int unsigned k = 2; k <= LAST; k++) t_q[k] <= t_q[k-1];
      end
    end
  end

  always_comb begin
    tag_sel = t_q[2];
    for (int unsigned k = 2; k <= LAST; k++) begin
      if (k == w_eff + 1 && f_w1) tag_sel = t_q[k];
    end
  end
`else
  assign tag_sel = '0;
`endif

  // ---------------------------------------------------------------------------
  // Write FSM: evaluate one cycle after PBEND, push the next
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [BLKW-1:0] blk_q, cap_blk_q;
  logic            cap_scnd_q, cap_shared_q;
  logic [L1NW-1:0] cap_tag_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: if (PBEND) state_d = StEval;
      StEval: begin
        if (yes) begin
          state_d = StPush;
          pend_d  = PBEND;
        end else if (!PBEND) begin
          state_d = StIdle;
        end
      end
      StPush: begin
        state_d = (PBEND | pend_q) ? StEval : StIdle;
        pend_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      pend_q       <= 1'b0;
      blk_q        <= '0;
      cap_blk_q    <= '0;
      cap_scnd_q   <= 1'b0;
      cap_shared_q <= 1'b0;
      cap_tag_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (PBEND) blk_q <= BLKIN;
      if (state_q == StEval) begin
        cap_blk_q    <= blk_q;
        cap_scnd_q   <= f_w1;
        cap_shared_q <= f_w & f_w1;
        cap_tag_q    <= tag_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [FDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovfl_q;
  logic          push, pop_ok, push_ok, full;
  logic [DW-1:0] head;

  assign full    = (count_q == CW'(FDEPTH));
  assign push    = (state_q == StPush);
  assign pop_ok  = POP & (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_q] <= {cap_blk_q, cap_scnd_q, cap_shared_q, cap_tag_q};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovfl_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok & ~pop_ok)      count_q <= count_q + CW'(1);
      else if (~push_ok & pop_ok) count_q <= count_q - CW'(1);
      if (push & ~push_ok) ovfl_q <= 1'b1;
    end
  end

  assign head = DAV ? mem[rd_ptr_q] : '0;

  assign DAV         = (count_q != '0);
  assign FULL        = full;
  assign OVFL        = ovfl_q;
  assign COUNT       = count_q;
  assign BLKOUT      = head[DW-1 -: BLKW];
  assign SCND_BLK    = head[L1NW+1];
  assign SCND_SHARED = head[L1NW];
  assign L1ANUM      = head[L1NW-1:0];

endmodule
